ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares the single-port RAM64_8 (64 x WORDSIZE) between requesters A and B (e.g. instruction fetch and data port).
- Accepts one request at a time, drives the RAM address, data and write-enable from registers, captures read data, and returns a one-cycle ack with the result.
- Sits between the CPU datapath ports and RAM64_8, which writes on the clk rising edge and reads combinationally from its address.

Parameters:
- DATA_W, `WORDSIZE (8): data width, matching RAM64_8.
- ADDR_W, 6: RAM address width, 64 words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A: request, held high until a_ack.
- a_we  in  1  requester A: 1 = write, 0 = read; stable while a_req is high.
- a_addr  in  ADDR_W  requester A: address; stable while a_req is high.
- a_wdata  in  DATA_W  requester A: write data; stable while a_req is high.
- a_ack  out  1  requester A: one-cycle completion pulse.
- a_rdata  out  DATA_W  requester A: read data, valid while a_ack=1 and held afterwards.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: identical set for requester B.
- ram_addr  out  ADDR_W  registered, to RAM64_8.addr.
- ram_wdata  out  DATA_W  registered, to RAM64_8.data_in.
- ram_we  out  1  registered, to RAM64_8.write_en.
- ram_rdata  in  DATA_W  from RAM64_8.data_out.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset (clr_n=0, async): state=IDLE; ram_we=0, ram_addr=0, ram_wdata=0, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, last_gnt=B, so A wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE, ram_we=0.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not last_gnt.
  - On a grant: register the granted addr/wdata/we into ram_addr/ram_wdata/ram_we, set last_gnt=granted port, go to ACCESS.
- ACCESS (1 cycle):
  - RAM sees stable addr/data/we. A write commits at the rising edge ending ACCESS.
  - A read captures ram_rdata into the granted port's rdata register at that edge; the other port's rdata is unchanged.
  - ram_we clears at that edge. Go to RESP.
- RESP (1 cycle): the granted port's ack=1, the other ack=0. Go to IDLE.
- Latency: request seen in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2. Back-to-back requests from different ports need 3 cycles each; there is no pipelining.
- Handshake:
  - The requester samples ack at the rising edge and drops req by the next cycle.
  - If req is still high in the IDLE cycle after RESP, it is a new request.
  - On a write, rdata is not updated.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B. A port waits at most one other transaction.
- A request that arrives while busy waits. The requester must hold req and its fields.
- Write-only and read-only streams behave identically in timing.
- Addresses use the full ADDR_W; no wrap or range check is needed (63 is valid).
- Reset mid-operation, any state:
  - Immediate return to IDLE with ram_we=0 and no ack.
  - A write already committed at an earlier edge stays in RAM.
  - An aborted ACCESS write does not commit if clr_n falls before the edge.

Decomposition:
- defines.v (shared): add `RAM_ADDR_W 6 and the state encodings `ARB_IDLE 2'd0, `ARB_ACCESS 2'd1, `ARB_RESP 2'd2. `WORDSIZE is reused.
- Sub-module rr_arb2, kept small and separate:
  - Combinational two-way round-robin pick from (a_req, b_req, last_gnt).
  - Outputs gnt_a, gnt_b.
  - The last_gnt register stays in ram_arbiter.

Test Plan:
- Reset then idle: clr_n=0 for 2 cycles, then 1, no req -> all outputs 0, busy=0, ram_we never asserted.
- Single write/read on A:
  - Write a_addr=0, a_wdata=10 -> ram_we=1 exactly one cycle with ram_addr=0; a_ack at N+2.
  - Then read a_addr=0 -> a_rdata=10 with a_ack at N+2; b_rdata stays 0.
- Tie and alternation: both write simultaneously, A addr=1 data=12 and B addr=2 data=2, held until ack -> A granted first, B 3 cycles later. Read-back gives 12 and 2.
- Sustained contention: A and B both issue 4 reads each, re-requesting the cycle after each ack -> ack sequence A, B, A, B, A, B, A, B; no port acked twice in a row.
- Boundary address: B writes addr=63 data=3, then A reads 63 -> a_rdata=3; ram_addr=63 observed.
- Reset mid-op: A writes addr=5 data=77; clr_n pulled low during ACCESS before the edge -> ram_we=0 immediately, no a_ack, state IDLE; a later read of addr 5 does not return 77 (bench preloads 0).

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths, FSM states and port ids for the RAM arbiter
package ram_arbiter_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; a tie goes to the port not granted last
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic  i_a_req,
  input  logic  i_b_req,
  input  port_t i_last_gnt,
  output logic  o_gnt_a,
  output logic  o_gnt_b
);
  assign o_gnt_a = i_a_req & (!i_b_req | (i_last_gnt == PORT_B));
  assign o_gnt_b = i_b_req & (!i_a_req | (i_last_gnt == PORT_A));
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between requesters A and B, one 3-cycle transaction at a time
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  arb_state_t        r_state, w_next;
  port_t             r_last_gnt, r_gnt;
  logic              w_gnt_a, w_gnt_b, w_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_a_rdata, r_b_rdata;

  rr_arb2 u_rr (
    .i_a_req    (a_req),
    .i_b_req    (b_req),
    .i_last_gnt (r_last_gnt),
    .o_gnt_a    (w_gnt_a),
    .o_gnt_b    (w_gnt_b)
  );

  assign w_grant = w_gnt_a | w_gnt_b;

  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)   ? (w_grant ? ACCESS : IDLE) :
             (r_state == ACCESS) ? RESP : IDLE;
  end

  // read data is captured at the edge that ends ACCESS, while the RAM address is still stable
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_last_gnt <= PORT_B;
      r_gnt      <= PORT_A;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      if (r_state == IDLE && w_grant) begin
        r_addr     <= w_gnt_b ? b_addr : a_addr;
        r_wdata    <= w_gnt_b ? b_wdata : a_wdata;
        r_we       <= w_gnt_b ? b_we : a_we;
        r_last_gnt <= port_t'(w_gnt_b);
        r_gnt      <= port_t'(w_gnt_b);
      end
      if (r_state == ACCESS) begin
        r_we <= 1'b0;
        if (!r_we && r_gnt == PORT_A) r_a_rdata <= ram_rdata;
        if (!r_we && r_gnt == PORT_B) r_b_rdata <= ram_rdata;
      end
    end

  assign a_ack     = (r_state == RESP) && (r_gnt == PORT_A);
  assign b_ack     = (r_state == RESP) && (r_gnt == PORT_B);
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_we    = r_we;
  assign busy      = (r_state == ACCESS) || (r_state == RESP);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a RAM model and a memory-level reference
module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [5:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, ram_we, busy;
  logic [7:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic [5:0] ram_addr;

  logic [7:0] mem [64] = '{default: 8'h0};
  logic [7:0] model_mem [64] = '{default: 8'h0};
  logic [7:0] model_rd [2] = '{8'h0, 8'h0};
  int         total = 0, bad = 0;
  int         acks [2] = '{0, 0};
  int         log_q [$];
  int         we_cnt = 0;
  logic [5:0] we_addr = '0;
  int         la, lb, lat;

  ram_arbiter dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      we_addr = ram_addr;
    end
    if (clr_n) check("one_ack", {31'b0, a_ack & b_ack}, 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input logic [5:0] ad, input logic [7:0] wd);
    if (p) begin
      b_req = r; b_we = we; b_addr = ad; b_wdata = wd;
    end else begin
      a_req = r; a_we = we; a_addr = ad; a_wdata = wd;
    end
  endtask

  // one full handshake for port p; the reference memory is updated in ack order
  task automatic txn(input bit p, input bit we, input logic [5:0] ad, input logic [7:0] wd, output int lat_o);
    int n = 0;
    bit got = 0;
    int oth = p ? 0 : 1;
    int other0 = acks[oth];
    drive(p, 1'b1, we, ad, wd);
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = p ? b_ack : a_ack;
    end
    lat_o = n;
    check(p ? "b_ack_seen" : "a_ack_seen", {31'b0, got}, 1);
    if (got) begin
      acks[p]++;
      log_q.push_back(int'(p));
      check("busy_resp", {31'b0, busy}, 1);
      check("wait_other", {31'b0, (acks[oth] - other0) <= 1}, 1);
      check("lat_bound", {31'b0, n <= 6}, 1);
      if (we) model_mem[ad] = wd;
      else    model_rd[p] = model_mem[ad];
      check(p ? "b_rdata" : "a_rdata", {24'b0, p ? b_rdata : a_rdata}, {24'b0, model_rd[p]});
    end
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    model_rd = '{8'h0, 8'h0};
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ram_we", {31'b0, ram_we}, 0);
    check("rst_ram_addr", {26'b0, ram_addr}, 0);
    check("rst_ram_wdata", {24'b0, ram_wdata}, 0);
    check("rst_acks", {30'b0, a_ack, b_ack}, 0);
    check("rst_rdata", {16'b0, a_rdata, b_rdata}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_we_never", we_cnt, 0);
    @(posedge clk);
    #1;

    w0 = we_cnt;
    txn(0, 1, 6'd0, 8'd10, lat);
    check("a_wr_lat", lat, 3);
    check("a_wr_we_cycles", we_cnt - w0, 1);
    check("a_wr_we_addr", {26'b0, we_addr}, 0);
    txn(0, 0, 6'd0, 8'd0, lat);
    check("a_rd_lat", lat, 3);
    check("a_rd_val", {24'b0, a_rdata}, 10);
    check("b_rdata_hold", {24'b0, b_rdata}, 0);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 0);
    @(posedge clk);
    #1;

    do_reset();
    fork
      txn(0, 1, 6'd1, 8'd12, la);
      txn(1, 1, 6'd2, 8'd2, lb);
    join
    check("tie_a_lat", la, 3);
    check("tie_b_lat", lb, 6);
    txn(1, 0, 6'd2, 8'd0, lat);
    check("tie_rd_b", {24'b0, b_rdata}, 2);
    txn(0, 0, 6'd1, 8'd0, lat);
    check("tie_rd_a", {24'b0, a_rdata}, 12);

    do_reset();
    log_q.delete();
    fork
      for (int i = 0; i < 4; i++) txn(0, 0, 6'($urandom_range(0, 63)), 8'd0, la);
      for (int j = 0; j < 4; j++) txn(1, 0, 6'($urandom_range(0, 63)), 8'd0, lb);
    join
    check("alt_count", log_q.size(), 8);
    foreach (log_q[k]) check("alt_order", log_q[k], k % 2);

    txn(1, 1, 6'd63, 8'd3, lat);
    check("b63_we_addr", {26'b0, we_addr}, 63);
    txn(0, 0, 6'd63, 8'd0, lat);
    check("a63_rdata", {24'b0, a_rdata}, 3);

    w0 = log_q.size();
    drive(0, 1'b1, 1'b1, 6'd5, 8'd77);
    @(posedge clk);
    #2;
    check("mid_we_before", {31'b0, ram_we}, 1);
    clr_n = 1'b0;
    #1;
    check("mid_we_after", {31'b0, ram_we}, 0);
    check("mid_busy", {31'b0, busy}, 0);
    check("mid_ack", {30'b0, a_ack, b_ack}, 0);
    drive(0, 1'b0, 1'b0, 6'd0, 8'd0);
    model_rd = '{8'h0, 8'h0};
    @(posedge clk);
    #1;
    check("mid_mem5", {24'b0, mem[5]}, 0);
    @(negedge clk);
    check("mid_no_ack", {30'b0, a_ack, b_ack}, 0);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_no_log", log_q.size(), w0);
    txn(0, 0, 6'd5, 8'd0, lat);
    check("mid_rd5", {24'b0, a_rdata}, 0);

    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        txn(0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom), la);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        txn(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom), lb);
      end
    join
    for (int m = 0; m < 8; m++) check("final_mem", {24'b0, mem[m]}, {24'b0, model_mem[m]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
